// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, position type and the framebuffer
// address helpers used by the scan timer.
package vga_timing_pkg;

    localparam int VGA_CLK_DIV = 2;
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;

    localparam int H_TOTAL      = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL      = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int H_SYNC_START = VGA_H_DISP + VGA_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC;
    localparam int V_SYNC_START = VGA_V_DISP + VGA_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC;

    localparam int FB_W   = 128;
    localparam int FB_H   = 128;
    localparam int CELL_W = 4;
    localparam int CELL_H = 8;

    typedef logic [9:0] coord_t;
    typedef logic [8:0] fb_addr_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;

    // Raster successor of p; y advances only on the x wrap.
    function automatic pos_t next_pos(input pos_t p, input coord_t h_last, input coord_t v_last);
        pos_t r;
        r = p;
        if (p.x == h_last) begin
            r.x = '0;
            r.y = (p.y == v_last) ? '0 : p.y + 10'd1;
        end else begin
            r.x = p.x + 10'd1;
        end
        return r;
    endfunction

    // 32 cells per row of 4-wide cells, 16 rows of 8-high cells; outside 128x128 it aliases.
    function automatic fb_addr_t fb_word_addr(input pos_t p);
        return {p.y[6:3], p.x[6:2]};
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to the pixel rate: a registered one-clk
// strobe in the last clk of every CLK_DIV-clk pixel period.
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_tick
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick_q;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_d == LAST);
        end
    end

    assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_scan_timer.sv
// Raster timer: h/v counters advanced on pixel_tick, sync/blank decode of the
// new position, and a one-pixel-lookahead framebuffer word address.
module vga_scan_timer
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV,
    parameter int H_DISP  = VGA_H_DISP,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_DISP  = VGA_V_DISP,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic [8:0] fb_addr,
    output logic       frame_start
);
    localparam coord_t H_LAST   = coord_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t HS_START = coord_t'(H_DISP + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISP + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISP + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISP + V_FP + V_SYNC);
    localparam coord_t HD       = coord_t'(H_DISP);
    localparam coord_t VD       = coord_t'(V_DISP);

    logic     tick;
    pos_t     pos_q, pos_d, look_d;
    logic     hsync_q, vsync_q, video_on_q, frame_start_q;
    fb_addr_t fb_addr_q;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixel_tick(tick)
    );

    // pos_d is what the counters load on the tick; look_d is the pixel after it,
    // giving a 1-cycle sync RAM a full pixel period to present that word.
    always_comb begin
        pos_d  = next_pos(pos_q, H_LAST, V_LAST);
        look_d = next_pos(pos_d, H_LAST, V_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            fb_addr_q     <= '0;
            frame_start_q <= 1'b0;
        end else if (tick) begin
            pos_q         <= pos_d;
            hsync_q       <= !((pos_d.x >= HS_START) && (pos_d.x < HS_END));
            vsync_q       <= !((pos_d.y >= VS_START) && (pos_d.y < VS_END));
            video_on_q    <= (pos_d.x < HD) && (pos_d.y < VD);
            fb_addr_q     <= fb_word_addr(look_d);
            frame_start_q <= (pos_d.x == '0) && (pos_d.y == '0);
        end else begin
            frame_start_q <= 1'b0;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pos_q.x;
    assign pixel_y     = pos_q.y;
    assign pixel_tick  = tick;
    assign fb_addr     = fb_addr_q;
    assign frame_start = frame_start_q;

endmodule
